// File: rtl/fsm_step_ctrl.sv
// Run-control sequencer for a table-driven state register: programmable next-state
// table, RUN/STOP/STEP/LOAD commands, breakpoint halt and a saturating advance counter.
module fsm_step_ctrl #(
  parameter int SW    = 3,
  parameter int CNTW  = 8,
  parameter int MATCH = 1
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            cfg_we,
  input  logic [SW-1:0]   cfg_addr,
  input  logic [SW-1:0]   cfg_data,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [SW-1:0]   cmd_arg,
  input  logic            bp_en,
  input  logic [SW-1:0]   bp_state,
  output logic [SW-1:0]   cs,
  output logic            out,
  output logic            running,
  output logic            bp_hit,
  output logic [CNTW-1:0] step_cnt
);

  localparam int NENT = 1 << SW;

  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_STOP = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BREAK = 2'd2
  } state_t;

  state_t             r_state;
  logic [SW-1:0]      r_cs;
  logic [CNTW-1:0]    r_cnt;
  logic               r_running;
  logic               r_bp_hit;
  logic [SW-1:0]      r_tbl [NENT];

  logic               w_accept;
  logic [SW-1:0]      w_next;
  logic [CNTW-1:0]    w_cnt_inc;
  logic               w_bp_match;

  // Power-on next-state table; entries past the first eight start at zero.
  function automatic logic [SW-1:0] tbl_rst(input int idx);
    logic [SW-1:0] v;
    case (idx)
      0:       v = SW'(2);
      1:       v = SW'(1);
      2:       v = SW'(0);
      3:       v = SW'(5);
      4:       v = SW'(1);
      5:       v = SW'(7);
      6:       v = SW'(1);
      7:       v = SW'(6);
      default: v = SW'(0);
    endcase
    return v;
  endfunction

  assign cmd_ready  = ~cfg_we;
  assign w_accept   = cmd_valid & ~cfg_we;
  assign w_next     = r_tbl[r_cs];
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNTW'(1);
  assign w_bp_match = bp_en & (w_next == bp_state);

  // Table writes land at the edge, so an advance on the same edge still reads the old entry.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < NENT; i++) begin
        r_tbl[i] <= tbl_rst(i);
      end
    end else begin
      if (cfg_we) begin
        r_tbl[cfg_addr] <= cfg_data;
      end
    end
  end

  // Controller: commands accepted in RUN that have no effect fall through to the normal advance.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state   <= S_IDLE;
      r_cs      <= SW'(0);
      r_cnt     <= CNTW'(0);
      r_running <= 1'b0;
      r_bp_hit  <= 1'b0;
    end else begin
      if (w_accept && (cmd_op == OP_LOAD)) begin
        r_cs      <= cmd_arg;
        r_cnt     <= CNTW'(0);
        r_state   <= S_IDLE;
        r_running <= 1'b0;
        r_bp_hit  <= 1'b0;
      end else if (w_accept && (cmd_op == OP_STOP)) begin
        r_state   <= S_IDLE;
        r_running <= 1'b0;
        r_bp_hit  <= 1'b0;
      end else if (w_accept && (cmd_op == OP_RUN) && (r_state != S_RUN)) begin
        r_state   <= S_RUN;
        r_running <= 1'b1;
        r_bp_hit  <= 1'b0;
      end else if (w_accept && (cmd_op == OP_STEP) && (r_state != S_RUN)) begin
        r_cs      <= w_next;
        r_cnt     <= w_cnt_inc;
        r_state   <= S_IDLE;
        r_running <= 1'b0;
        r_bp_hit  <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_cs  <= w_next;
        r_cnt <= w_cnt_inc;
        if (w_bp_match) begin
          r_state   <= S_BREAK;
          r_running <= 1'b0;
          r_bp_hit  <= 1'b1;
        end else begin
          r_state   <= S_RUN;
          r_running <= 1'b1;
          r_bp_hit  <= 1'b0;
        end
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign cs       = r_cs;
  assign out      = (r_cs == SW'(MATCH));
  assign running  = r_running;
  assign bp_hit   = r_bp_hit;
  assign step_cnt = r_cnt;

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Vector-table bench for fsm_step_ctrl; a second instance with a 4-bit counter
// shares the stimulus to exercise counter saturation.
module tb_fsm_step_ctrl;

  localparam logic [1:0] R = 2'd0, S = 2'd1, T = 2'd2, L = 2'd3;

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [2:0] data;
    logic       vld;
    logic [1:0] op;
    logic [2:0] arg;
    logic       bpe;
    logic [2:0] bps;
    int         cs;
    int         cnt;
    int         run;
    int         bp;
  } vec_t;

  logic       clk;
  logic       arst;
  logic       cfg_we;
  logic [2:0] cfg_addr, cfg_data, cmd_arg, bp_state;
  logic       cmd_valid, bp_en;
  logic [1:0] cmd_op;
  logic       rdy8, rdy4, out8, out4, run8, run4, bp8, bp4;
  logic [2:0] cs8, cs4;
  logic [7:0] cnt8;
  logic [3:0] cnt4;

  int   n_chk;
  int   n_fail;
  vec_t vecs[$];
  vec_t exp_q[$];

  fsm_step_ctrl #(.SW(3), .CNTW(8), .MATCH(1)) u_dut (
    .clk(clk), .arst(arst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cmd_valid(cmd_valid), .cmd_ready(rdy8), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .bp_en(bp_en), .bp_state(bp_state), .cs(cs8), .out(out8), .running(run8),
    .bp_hit(bp8), .step_cnt(cnt8)
  );

  fsm_step_ctrl #(.SW(3), .CNTW(4), .MATCH(1)) u_dut4 (
    .clk(clk), .arst(arst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cmd_valid(cmd_valid), .cmd_ready(rdy4), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .bp_en(bp_en), .bp_state(bp_state), .cs(cs4), .out(out4), .running(run4),
    .bp_hit(bp4), .step_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input int a, input int d, input logic v,
                              input logic [1:0] op, input int arg, input logic bpe, input int bps,
                              input int ecs, input int ecnt, input int erun, input int ebp);
    vec_t x;
    x.we = we; x.addr = 3'(a); x.data = 3'(d); x.vld = v; x.op = op; x.arg = 3'(arg);
    x.bpe = bpe; x.bps = 3'(bps); x.cs = ecs; x.cnt = ecnt; x.run = erun; x.bp = ebp;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    int e4;
    e4 = (e.cnt > 15) ? 15 : e.cnt;
    chk({tag, " cs"}, int'(cs8), e.cs);
    chk({tag, " step_cnt"}, int'(cnt8), e.cnt);
    chk({tag, " running"}, int'(run8), e.run);
    chk({tag, " bp_hit"}, int'(bp8), e.bp);
    chk({tag, " out"}, int'(out8), (e.cs == 1) ? 1 : 0);
    chk({tag, " cs4"}, int'(cs4), e.cs);
    chk({tag, " step_cnt4"}, int'(cnt4), e4);
  endtask

  // Drive one vector, predict into the scoreboard, compare after the edge.
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    cfg_we = v.we; cfg_addr = v.addr; cfg_data = v.data;
    cmd_valid = v.vld; cmd_op = v.op; cmd_arg = v.arg;
    bp_en = v.bpe; bp_state = v.bps;
    exp_q.push_back(v);
    #1;
    chk({tag, " cmd_ready"}, int'(rdy8), v.we ? 0 : 1);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_outs(tag, e);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    arst = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 3'd0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 3'd0; bp_en = 1'b0; bp_state = 3'd0;
    repeat (2) @(negedge clk);
    arst = 1'b1;
    #1;
    check_outs("reset", mk(0, 0, 0, 0, R, 0, 0, 0, 0, 0, 0, 0));

    // RUN with default table: 2,0,2,0
    vecs.push_back(mk(0,0,0,1,R,0,0,0, 0,0,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,0,0, 2,1,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,0,0, 0,2,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,0,0, 2,3,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,0,0, 0,4,1,0));
    // LOAD 3, breakpoint on 7
    vecs.push_back(mk(0,0,0,1,L,3,1,7, 3,0,0,0));
    vecs.push_back(mk(0,0,0,1,R,0,1,7, 3,0,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,1,7, 5,1,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,1,7, 7,2,0,1));
    vecs.push_back(mk(0,0,0,0,R,0,1,7, 7,2,0,1));
    // STEP out of BREAK, STEP, then RUN on the 1->1 self-loop
    vecs.push_back(mk(0,0,0,1,T,0,1,7, 6,3,0,0));
    vecs.push_back(mk(0,0,0,1,T,0,1,7, 1,4,0,0));
    vecs.push_back(mk(0,0,0,1,R,0,1,7, 1,4,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,1,7, 1,5,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,1,7, 1,6,1,0));
    vecs.push_back(mk(0,0,0,1,S,0,1,7, 1,6,0,0));
    // Table write of entry 2 <= 4 while running, STOP stalled behind it
    vecs.push_back(mk(0,0,0,1,L,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,1,R,0,0,0, 0,0,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,0,0, 2,1,1,0));
    vecs.push_back(mk(1,2,4,1,S,0,0,0, 0,2,1,0));
    vecs.push_back(mk(1,2,4,1,S,0,0,0, 2,3,1,0));
    vecs.push_back(mk(1,2,4,1,S,0,0,0, 4,4,1,0));
    vecs.push_back(mk(1,2,4,1,S,0,0,0, 1,5,1,0));
    vecs.push_back(mk(1,2,4,1,S,0,0,0, 1,6,1,0));
    vecs.push_back(mk(0,0,0,1,S,0,0,0, 1,6,0,0));
    // RUN from BREAK leaves the breakpoint; STEP/RUN in RUN are no-ops
    vecs.push_back(mk(0,0,0,1,L,3,1,7, 3,0,0,0));
    vecs.push_back(mk(0,0,0,1,R,0,1,7, 3,0,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,1,7, 5,1,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,1,7, 7,2,0,1));
    vecs.push_back(mk(0,0,0,1,R,0,1,7, 7,2,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,1,7, 6,3,1,0));
    vecs.push_back(mk(0,0,0,0,R,0,1,7, 1,4,1,0));
    vecs.push_back(mk(0,0,0,1,T,0,1,7, 1,5,1,0));
    vecs.push_back(mk(0,0,0,1,R,0,1,7, 1,6,1,0));
    // STEP into the breakpoint state does not break
    vecs.push_back(mk(0,0,0,1,L,5,1,7, 5,0,0,0));
    vecs.push_back(mk(0,0,0,1,T,0,1,7, 7,1,0,0));
    vecs.push_back(mk(0,0,0,1,S,0,1,7, 7,1,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("v%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-RUN, between edges
    apply("ar0", mk(0,0,0,1,L,0,0,0, 0,0,0,0));
    apply("ar1", mk(0,0,0,1,R,0,0,0, 0,0,1,0));
    apply("ar2", mk(0,0,0,0,R,0,0,0, 2,1,1,0));
    #2;
    arst = 1'b0;
    #1;
    check_outs("arst", mk(0,0,0,0,R,0,0,0, 0,0,0,0));
    @(negedge clk);
    arst = 1'b1;
    apply("ar3", mk(0,0,0,1,L,2,0,0, 2,0,0,0));
    apply("ar4", mk(0,0,0,1,T,0,0,0, 0,1,0,0));

    // Counter saturation (4-bit instance stops at 15)
    apply("sat_ld", mk(0,0,0,1,L,1,0,0, 1,0,0,0));
    apply("sat_run", mk(0,0,0,1,R,0,0,0, 1,0,1,0));
    for (int i = 1; i <= 20; i++) begin
      apply($sformatf("sat%0d", i), mk(0,0,0,0,R,0,0,0, 1,i,1,0));
    end
    apply("sat_stop", mk(0,0,0,1,S,0,0,0, 1,20,0,0));
    apply("sat_ld0", mk(0,0,0,1,L,0,0,0, 0,0,0,0));

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
